// File: rtl/fsk_deframer.sv
// fsk_deframer: frame recovery for the FSK demodulator bit stream.
// Hunts for SYNC_WORD (up to SYNC_TOL bit errors), reads a length byte and
// assembles payload bytes MSB-first into a 1-deep valid/ready output buffer,
// flagging frame start, clean end and any abort (bad length, overflow, timeout).
// Optional CRC-8 trailer check (poly 0x07, init 0x00, over length + payload)
// is enabled by defining FSK_DEFRAMER_CRC_EN.
module fsk_deframer #(
    parameter int                SYNC_W    = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hD391,
    parameter int                SYNC_TOL  = 0,
    parameter int                MAX_LEN   = 32,
    parameter int                TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] frame_len,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

`ifdef FSK_DEFRAMER_CRC_EN
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CRC} state_t;
`else
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD} state_t;
`endif

    state_t            state;
    logic [SYNC_W-1:0] sync_sr;
    logic [7:0]        byte_sr;
    logic [2:0]        bit_cnt;
    logic [7:0]        remaining;
    logic [TMO_W-1:0]  tmo_cnt;
`ifdef FSK_DEFRAMER_CRC_EN
    logic [7:0]        crc_q;
`endif

    logic [SYNC_W-1:0] sync_next;
    logic [7:0]        byte_next;
    logic              byte_done;
    logic              sync_hit;
    logic              tmo_hit;
    logic              out_busy;

    // Number of bit positions in which two sync-width words differ.
    function automatic int mismatch_count(input logic [SYNC_W-1:0] a,
                                          input logic [SYNC_W-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (a[i] != b[i]) n++;
        end
        return n;
    endfunction

`ifdef FSK_DEFRAMER_CRC_EN
    // Bitwise CRC-8 (poly 0x07) update over one byte, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Shift-register views that already include the bit strobed this cycle,
    // so a sync match or byte completion is acted on at the same edge.
    assign sync_next = {sync_sr[SYNC_W-2:0], bit_in};
    assign byte_next = {byte_sr[6:0], bit_in};
    assign byte_done = bit_valid && (bit_cnt == 3'd7);
    assign sync_hit  = bit_valid && (mismatch_count(sync_next, SYNC_WORD) <= SYNC_TOL);
    assign tmo_hit   = !bit_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign out_busy  = byte_valid && !byte_ready;

    // Idle-cycle counter: restarts on every bit strobe and is held at 0 while hunting.
    always_ff @(posedge clk) begin
        if (!rst || state == S_HUNT || bit_valid) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Frame FSM with bit/byte assembly, output buffer and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_HUNT;
            sync_sr     <= '0;
            byte_sr     <= '0;
            bit_cnt     <= '0;
            remaining   <= '0;
            frame_len   <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
`ifdef FSK_DEFRAMER_CRC_EN
            crc_q       <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;

            if (byte_ready) byte_valid <= 1'b0;

            if (bit_valid) begin
                sync_sr <= sync_next;
                byte_sr <= byte_next;
                bit_cnt <= bit_cnt + 3'd1;
            end

            case (state)
                S_HUNT: begin
                    // Byte alignment starts with the first bit after the sync word.
                    bit_cnt <= '0;
                    if (sync_hit) state <= S_LEN;
                end

                S_LEN: begin
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= S_HUNT;
                        sync_sr   <= '0;
                    end else if (byte_done) begin
                        if (byte_next == 8'd0 || int'(byte_next) > MAX_LEN) begin
                            frame_err <= 1'b1;
                            state     <= S_HUNT;
                            sync_sr   <= '0;
                        end else begin
                            frame_len   <= byte_next;
                            frame_start <= 1'b1;
                            remaining   <= byte_next;
                            state       <= S_PAYLOAD;
`ifdef FSK_DEFRAMER_CRC_EN
                            crc_q       <= crc8_byte(8'h00, byte_next);
`endif
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= S_HUNT;
                        sync_sr   <= '0;
                    end else if (byte_done) begin
                        if (out_busy) begin
                            // Consumer still holds the previous byte: drop the new
                            // one, keep the held byte valid, abort the frame.
                            frame_err <= 1'b1;
                            state     <= S_HUNT;
                            sync_sr   <= '0;
                        end else begin
                            byte_out   <= byte_next;
                            byte_valid <= 1'b1;
                            remaining  <= remaining - 8'd1;
`ifdef FSK_DEFRAMER_CRC_EN
                            crc_q      <= crc8_byte(crc_q, byte_next);
                            if (remaining == 8'd1) state <= S_CRC;
`else
                            if (remaining == 8'd1) begin
                                frame_end <= 1'b1;
                                state     <= S_HUNT;
                                sync_sr   <= '0;
                            end
`endif
                        end
                    end
                end

`ifdef FSK_DEFRAMER_CRC_EN
                S_CRC: begin
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= S_HUNT;
                        sync_sr   <= '0;
                    end else if (byte_done) begin
                        // Trailer byte is checked only; it is never delivered.
                        if (byte_next == crc_q) frame_end <= 1'b1;
                        else                    frame_err <= 1'b1;
                        state   <= S_HUNT;
                        sync_sr <= '0;
                    end
                end
`endif

                default: begin
                    state   <= S_HUNT;
                    sync_sr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_deframer.sv
// tb_fsk_deframer: scoreboard bench for fsk_deframer. Two instances share the
// bit stream: dut (SYNC_TOL=0) is fully checked, dut_tol (SYNC_TOL=1) is used
// only for the sync-tolerance case.
module tb_fsk_deframer;

    localparam int PER = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b0;

    logic [7:0] byte_out, frame_len;
    logic       byte_valid, frame_start, frame_end, frame_err;
    logic [7:0] t_byte_out, t_frame_len;
    logic       t_byte_valid, t_frame_start, t_frame_end, t_frame_err;

    fsk_deframer #(.SYNC_TOL(0)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_len(frame_len), .frame_start(frame_start),
        .frame_end(frame_end), .frame_err(frame_err)
    );

    fsk_deframer #(.SYNC_TOL(1)) dut_tol (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .byte_out(t_byte_out), .byte_valid(t_byte_valid), .byte_ready(byte_ready),
        .frame_len(t_frame_len), .frame_start(t_frame_start),
        .frame_end(t_frame_end), .frame_err(t_frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and event counters
    logic [7:0] exp_q[$];
    int   n_start = 0, n_end = 0, n_err = 0, n_acc = 0;
    int   tol_start = 0, tol_end = 0;
    logic [7:0] start_len = 8'h00;
    logic [7:0] end_byte = 8'h00;
    int   cyc = 0;
    int   strobe_cyc = -1;
    logic vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (frame_start) begin
                n_start++;
                start_len = frame_len;
            end
            if (frame_end) begin
                n_end++;
                end_byte = byte_out;
                check_eq("end_without_err", {31'd0, frame_err}, 32'd0);
            end
            if (frame_err) n_err++;
            if (byte_valid && !vld_prev) check_eq("byte_latency", cyc, strobe_cyc);
            if (byte_valid && byte_ready) begin
                n_acc++;
                if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(exp_q.size()), 32'd1);
                else                   check_eq("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
            end
            if (t_frame_start) tol_start++;
            if (t_frame_end)   tol_end++;
        end
        vld_prev = byte_valid;
    end

    // Reference CRC-8, poly 0x07, init 0, MSB first.
    function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        bit_in = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        strobe_cyc = cyc;
        bit_valid = 1'b0;
        repeat (PER - 2) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_hdr(input logic [15:0] sync);
        send_byte(8'h55);
        send_byte(8'h55);
        for (int i = 15; i >= 0; i--) send_bit(sync[i]);
    endtask

    // Full frame; bytes are pushed to the scoreboard when push=1.
    task automatic send_frame(input logic [15:0] sync, input logic [7:0] len,
                              input logic [7:0] pl[$], input bit push);
        logic [7:0] crc;
        send_hdr(sync);
        send_byte(len);
        crc = ref_crc8(8'h00, len);
        foreach (pl[i]) begin
            if (push) exp_q.push_back(pl[i]);
            send_byte(pl[i]);
            crc = ref_crc8(crc, pl[i]);
        end
`ifdef FSK_DEFRAMER_CRC_EN
        send_byte(crc);
`endif
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int s0, e0, r0, a0, ts0, te0;
        logic [7:0] pl[$];

        // Reset state
        repeat (3) @(posedge clk); #1;
        check_eq("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check_eq("rst_byte_out", {24'd0, byte_out}, 32'd0);
        check_eq("rst_frame_len", {24'd0, frame_len}, 32'd0);
        check_eq("rst_pulses", {29'd0, frame_start, frame_end, frame_err}, 32'd0);
        rst = 1'b1;
        byte_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Nominal frame A5 3C FF
        s0 = n_start; e0 = n_end; r0 = n_err; a0 = n_acc;
        pl = '{8'hA5, 8'h3C, 8'hFF};
        send_frame(16'hD391, 8'h03, pl, 1'b1);
        check_eq("nom_start", n_start - s0, 1);
        check_eq("nom_start_len", {24'd0, start_len}, 32'd3);
        check_eq("nom_frame_len", {24'd0, frame_len}, 32'd3);
        check_eq("nom_end", n_end - e0, 1);
        check_eq("nom_err", n_err - r0, 0);
        check_eq("nom_end_byte", {24'd0, end_byte}, 32'hFF);
        check_eq("nom_accepted", n_acc - a0, 3);
        check_eq("nom_q_empty", 32'(exp_q.size()), 0);
        repeat (100) @(posedge clk);

        // Sync word with one bit error: rejected at tol 0, accepted at tol 1
        s0 = n_start; r0 = n_err; ts0 = tol_start; te0 = tol_end;
        send_frame(16'hD390, 8'h03, pl, 1'b0);
        check_eq("sync_err_tol0_start", n_start - s0, 0);
        check_eq("sync_err_tol0_err", n_err - r0, 0);
        check_eq("sync_err_tol1_start", tol_start - ts0, 1);
        check_eq("sync_err_tol1_end", tol_end - te0, 1);
        check_eq("sync_err_tol1_len", {24'd0, t_frame_len}, 32'd3);
        repeat (100) @(posedge clk);

        // Illegal lengths 0x00 and 0x21
        s0 = n_start; r0 = n_err;
        send_hdr(16'hD391); send_byte(8'h00); repeat (8) @(posedge clk);
        check_eq("len0_err", n_err - r0, 1);
        send_hdr(16'hD391); send_byte(8'h21); repeat (8) @(posedge clk);
        check_eq("len21_err", n_err - r0, 2);
        check_eq("badlen_no_start", n_start - s0, 0);

        // MAX_LEN itself is legal (frame then left to time out)
        s0 = n_start; r0 = n_err;
        send_hdr(16'hD391); send_byte(8'h20); repeat (100) @(posedge clk);
        check_eq("len32_start", n_start - s0, 1);
        check_eq("len32_frame_len", {24'd0, frame_len}, 32'd32);
        check_eq("len32_timeout_err", n_err - r0, 1);

        // Recovery frame
        s0 = n_start; e0 = n_end;
        pl = '{8'h5A, 8'hC3};
        send_frame(16'hD391, 8'h02, pl, 1'b1);
        check_eq("rec1_start", n_start - s0, 1);
        check_eq("rec1_end", n_end - e0, 1);
        check_eq("rec1_q_empty", 32'(exp_q.size()), 0);
        repeat (100) @(posedge clk);

        // Backpressure overflow: 0x11 held, 0x22 dropped
        byte_ready = 1'b0;
        e0 = n_end; r0 = n_err; a0 = n_acc;
        send_hdr(16'hD391); send_byte(8'h02);
        exp_q.push_back(8'h11);
        send_byte(8'h11); send_byte(8'h22);
        repeat (4) @(posedge clk);
        check_eq("ovf_err", n_err - r0, 1);
        check_eq("ovf_no_end", n_end - e0, 0);
        check_eq("ovf_held_valid", {31'd0, byte_valid}, 32'd1);
        check_eq("ovf_held_byte", {24'd0, byte_out}, 32'h11);
        @(posedge clk); #1 byte_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        check_eq("ovf_accepted_once", n_acc - a0, 1);
        check_eq("ovf_q_empty", 32'(exp_q.size()), 0);
        check_eq("ovf_valid_clear", {31'd0, byte_valid}, 32'd0);
        repeat (100) @(posedge clk);

        // Timeout after 2 of 4 payload bytes
        e0 = n_end; r0 = n_err;
        send_hdr(16'hD391); send_byte(8'h04);
        exp_q.push_back(8'h01); send_byte(8'h01);
        exp_q.push_back(8'h02); send_byte(8'h02);
        repeat (32) @(posedge clk);
        check_eq("tmo_not_early", n_err - r0, 0);
        repeat (4) @(posedge clk);
        check_eq("tmo_err", n_err - r0, 1);
        check_eq("tmo_no_end", n_end - e0, 0);
        check_eq("tmo_q_empty", 32'(exp_q.size()), 0);

        // Recovery frame after timeout
        s0 = n_start; e0 = n_end;
        pl = '{8'h7E};
        send_frame(16'hD391, 8'h01, pl, 1'b1);
        check_eq("rec2_start", n_start - s0, 1);
        check_eq("rec2_end", n_end - e0, 1);
        check_eq("rec2_q_empty", 32'(exp_q.size()), 0);
        repeat (100) @(posedge clk);

        // Reset mid-frame drops a pending byte
        byte_ready = 1'b0;
        send_hdr(16'hD391); send_byte(8'h02); send_byte(8'h33);
        check_eq("midrst_pending", {31'd0, byte_valid}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_valid", {31'd0, byte_valid}, 32'd0);
        check_eq("midrst_frame_len", {24'd0, frame_len}, 32'd0);
        check_eq("midrst_byte_out", {24'd0, byte_out}, 32'd0);
        rst = 1'b1;
        byte_ready = 1'b1;
        repeat (4) @(posedge clk);

`ifdef FSK_DEFRAMER_CRC_EN
        // CRC-8 of {0x01, 0x01} is 0x12
        e0 = n_end; r0 = n_err;
        send_hdr(16'hD391); send_byte(8'h01);
        exp_q.push_back(8'h01); send_byte(8'h01);
        send_byte(8'h12); repeat (8) @(posedge clk);
        check_eq("crc_good_end", n_end - e0, 1);
        check_eq("crc_good_err", n_err - r0, 0);
        e0 = n_end; r0 = n_err;
        send_hdr(16'hD391); send_byte(8'h01);
        exp_q.push_back(8'h01); send_byte(8'h01);
        send_byte(8'h13); repeat (8) @(posedge clk);
        check_eq("crc_bad_err", n_err - r0, 1);
        check_eq("crc_bad_no_end", n_end - e0, 0);
        check_eq("crc_q_empty", 32'(exp_q.size()), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
